// File: rtl/rtc_timekeeper_if.sv
// Bus between the CPU/display side and the time-of-day counter.
// The master drives controls, load values and alarm settings; the slave
// (the timekeeper) returns the displayed time and its status pulses/flags.
interface rtc_timekeeper_if;
    logic       run;
    logic       mode12;
    logic       load;
    logic [4:0] load_hour;
    logic [5:0] load_min;
    logic [5:0] load_sec;
    logic       alarm_wr;
    logic [4:0] alarm_hour;
    logic [5:0] alarm_min;
    logic       alarm_en;
    logic       alarm_ack;

    logic [5:0] sec;
    logic [5:0] min;
    logic [4:0] hour;
    logic       pm;
    logic       sec_tick;
    logic       load_err;
    logic       alarm_irq;

    modport master (
        output run, mode12, load, load_hour, load_min, load_sec,
        output alarm_wr, alarm_hour, alarm_min, alarm_en, alarm_ack,
        input  sec, min, hour, pm, sec_tick, load_err, alarm_irq
    );

    modport slave (
        input  run, mode12, load, load_hour, load_min, load_sec,
        input  alarm_wr, alarm_hour, alarm_min, alarm_en, alarm_ack,
        output sec, min, hour, pm, sec_tick, load_err, alarm_irq
    );
endinterface

// File: rtl/rtc_timekeeper.sv
// Time-of-day counter: exact prescaler producing one tick per CLK_HZ cycles,
// sec/min/hour in 24-hour form internally, range-checked time load, a
// minute-resolution alarm with a sticky interrupt, and 12/24-hour display.
module rtc_timekeeper #(
    parameter int CLK_HZ = 50_000_000,
    parameter int PRE_W  = 32
) (
    input  logic               clock,
    input  logic               reset,
    rtc_timekeeper_if.slave    bus
);

    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(CLK_HZ - 1);

    logic [PRE_W-1:0] pre_count;
    logic [5:0]       sec_q;
    logic [5:0]       min_q;
    logic [4:0]       hour_q;
    logic [4:0]       alarm_hour_q;
    logic [5:0]       alarm_min_q;
    logic             tick_q;
    logic             err_q;
    logic             irq_q;

    logic             tick;
    logic             load_ok;
    logic             load_bad;
    logic             alarm_ok;
    logic             alarm_bad;
    logic             advance;
    logic             fire;
    logic [5:0]       sec_nxt;
    logic [5:0]       min_nxt;
    logic [4:0]       hour_nxt;
    logic [4:0]       disp_hour;

    // A load only takes effect when every field is in range, so stored
    // values can never leave their legal ranges.
    assign tick      = bus.run && (pre_count == PRE_MAX);
    assign load_ok   = bus.load && (bus.load_hour <= 5'd23)
                       && (bus.load_min <= 6'd59) && (bus.load_sec <= 6'd59);
    assign load_bad  = bus.load && !load_ok;
    assign alarm_ok  = bus.alarm_wr && (bus.alarm_hour <= 5'd23)
                       && (bus.alarm_min <= 6'd59);
    assign alarm_bad = bus.alarm_wr && !alarm_ok;
    assign advance   = tick && !load_ok;
    assign fire      = advance && bus.alarm_en && (sec_nxt == 6'd0)
                       && (min_nxt == alarm_min_q) && (hour_nxt == alarm_hour_q);

    // Time value one second after the current one, with sec/min/hour carries.
    always_comb begin
        sec_nxt  = sec_q + 6'd1;
        min_nxt  = min_q;
        hour_nxt = hour_q;
        if (sec_q == 6'd59) begin
            sec_nxt = 6'd0;
            if (min_q == 6'd59) begin
                min_nxt  = 6'd0;
                hour_nxt = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
            end else begin
                min_nxt = min_q + 6'd1;
            end
        end
    end

    // Prescaler: wraps on the tick, restarts on a valid load, holds when paused.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pre_count <= '0;
        end else if (load_ok || tick) begin
            pre_count <= '0;
        end else if (bus.run) begin
            pre_count <= pre_count + PRE_W'(1);
        end
    end

    // Time registers: a valid load beats the once-per-second advance.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sec_q  <= '0;
            min_q  <= '0;
            hour_q <= '0;
        end else if (load_ok) begin
            sec_q  <= bus.load_sec;
            min_q  <= bus.load_min;
            hour_q <= bus.load_hour;
        end else if (advance) begin
            sec_q  <= sec_nxt;
            min_q  <= min_nxt;
            hour_q <= hour_nxt;
        end
    end

    // Alarm setpoint, written only with in-range values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            alarm_hour_q <= '0;
            alarm_min_q  <= '0;
        end else if (alarm_ok) begin
            alarm_hour_q <= bus.alarm_hour;
            alarm_min_q  <= bus.alarm_min;
        end
    end

    // Status: tick and error pulses, plus the sticky irq where a fire beats an ack.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tick_q <= 1'b0;
            err_q  <= 1'b0;
            irq_q  <= 1'b0;
        end else begin
            tick_q <= advance;
            err_q  <= load_bad || alarm_bad;
            if (fire) begin
                irq_q <= 1'b1;
            end else if (bus.alarm_ack) begin
                irq_q <= 1'b0;
            end
        end
    end

    // Display hour: 24-hour passthrough, or 12-hour with 0 and 12 shown as 12.
    always_comb begin
        disp_hour = hour_q;
        if (bus.mode12) begin
            if ((hour_q == 5'd0) || (hour_q == 5'd12)) begin
                disp_hour = 5'd12;
            end else if (hour_q > 5'd12) begin
                disp_hour = hour_q - 5'd12;
            end
        end
    end

    assign bus.sec       = sec_q;
    assign bus.min       = min_q;
    assign bus.hour      = disp_hour;
    assign bus.pm        = (hour_q >= 5'd12);
    assign bus.sec_tick  = tick_q;
    assign bus.load_err  = err_q;
    assign bus.alarm_irq = irq_q;

endmodule
